// File: rtl/score_counter_if.sv
// rtl/score_counter_if.sv - bonus request handshake between game logic and score_counter
interface score_counter_if #(
    parameter int BONUS_DIGITS = 2
);
    logic                      add_valid;
    logic [4*BONUS_DIGITS-1:0] add_value;
    logic                      add_ready;
    logic                      add_done;

    modport master (output add_valid, output add_value, input add_ready, input add_done);
    modport slave  (input add_valid, input add_value, output add_ready, output add_done);
endinterface

// File: rtl/score_counter.sv
// rtl/score_counter.sv - BCD game-score engine: tick divider, serial bonus adder, saturation, high score
module score_counter #(
    parameter int TICK_DIV     = 50000000,
    parameter int DIGITS       = 4,
    parameter int BONUS_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  clear,
    score_counter_if.slave        bonus,
    output logic                  tick,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  new_high,
    output logic                  sat
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt;
    logic                wrap;
    logic                tick_pend;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] op;
    logic [IW-1:0]       idx;
    logic                carry;
    logic                done;
    logic                accept, do_inc, do_digit, do_commit;
    logic [4:0]          sum;
    logic [3:0]          sum_digit;

    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign wrap = run && (cnt == CW'(TICK_DIV - 1));

    // A pending tick blocks new bonuses so the increment is never starved.
    assign bonus.add_ready = (state == IDLE) && !tick_pend && !clear && !rst;
    assign bonus.add_done  = done;

    assign sum       = {1'b0, acc[4*int'(idx) +: 4]} + {1'b0, op[4*int'(idx) +: 4]} + {4'b0, carry};
    assign sum_digit = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        do_inc    = 1'b0;
        do_digit  = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                if (tick_pend) begin
                    do_inc = 1'b1;
                end else if (bonus.add_valid && bonus.add_ready) begin
                    accept  = 1'b1;
                    state_n = ADD;
                end
            end
            ADD: begin
                do_digit = 1'b1;
                if (idx == IW'(DIGITS - 1)) state_n = COMMIT;
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (clear) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tick      <= 1'b0;
            tick_pend <= 1'b0;
            score_bcd <= '0;
            sat       <= 1'b0;
            acc       <= '0;
            op        <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            tick      <= 1'b0;
            tick_pend <= 1'b0;
            score_bcd <= '0;
            sat       <= 1'b0;
            acc       <= '0;
            op        <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (run) cnt <= wrap ? '0 : cnt + CW'(1);
            tick <= wrap;
            done <= do_commit;

            if (wrap)        tick_pend <= 1'b1;
            else if (do_inc) tick_pend <= 1'b0;

            if (do_inc) begin
                if (score_bcd == NINES) sat <= 1'b1;
                else                    score_bcd <= bcd_inc(score_bcd);
            end

            if (accept) begin
                acc   <= score_bcd;
                op    <= (4*DIGITS)'(bonus.add_value[4*BONUS_DIGITS-1:0]);
                idx   <= '0;
                carry <= 1'b0;
            end

            if (do_digit) begin
                acc[4*int'(idx) +: 4] <= sum_digit;
                carry                 <= (sum > 5'd9);
                idx                   <= idx + IW'(1);
            end

            // Carry out of the top digit means overflow: pin at all-nines.
            if (do_commit) begin
                if (carry) begin
                    score_bcd <= NINES;
                    sat       <= 1'b1;
                end else begin
                    score_bcd <= acc;
                end
            end
        end
    end

    // BCD digits order the same as binary, so a plain compare suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_bcd <= '0;
            new_high <= 1'b0;
        end else if (score_bcd > high_bcd) begin
            high_bcd <= score_bcd;
            new_high <= 1'b1;
        end else begin
            new_high <= 1'b0;
        end
    end
endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - directed vector bench for score_counter
module tb_score_counter;
    localparam int TICK_DIV     = 4;
    localparam int DIGITS       = 4;
    localparam int BONUS_DIGITS = 2;

    logic        clk = 1'b0;
    logic        rst, run, clear;
    logic        tick, new_high, sat;
    logic [15:0] score_bcd, high_bcd;

    score_counter_if #(.BONUS_DIGITS(BONUS_DIGITS)) bus ();

    score_counter #(
        .TICK_DIV(TICK_DIV), .DIGITS(DIGITS), .BONUS_DIGITS(BONUS_DIGITS)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .bonus(bus.slave),
        .tick(tick), .score_bcd(score_bcd), .high_bcd(high_bcd),
        .new_high(new_high), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [7:0]  value;
        logic [15:0] exp_score;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[10];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Issue one bonus with run low; checks latency, no intermediate score, result.
    task automatic bonus_add(input logic [7:0] v, input logic [15:0] prior,
                             input logic [15:0] exp, input logic exp_sat, input string name);
        int   waited;
        int   lat;
        logic clean;
        waited = 0;
        while (!bus.add_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready"}, 32'(bus.add_ready), 32'd1);
        bus.add_valid = 1'b1;
        bus.add_value = v;
        @(negedge clk);
        bus.add_valid = 1'b0;
        lat   = 0;
        clean = 1'b1;
        while (!bus.add_done && lat < 20) begin
            if (score_bcd !== prior) clean = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(DIGITS + 1));
        check({name, " no partial"}, 32'(clean), 32'd1);
        check({name, " score"}, 32'(score_bcd), 32'(exp));
        check({name, " sat"}, 32'(sat), 32'(exp_sat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] prior;
        int          ticks;

        vecs[0] = '{1'b1, 8'h01, 16'h0001, 1'b0};
        vecs[1] = '{1'b0, 8'h09, 16'h0010, 1'b0};
        vecs[2] = '{1'b0, 8'h99, 16'h0109, 1'b0};
        vecs[3] = '{1'b0, 8'h91, 16'h0200, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 16'h0200, 1'b0};
        vecs[5] = '{1'b0, 8'h55, 16'h0255, 1'b0};
        vecs[6] = '{1'b0, 8'h45, 16'h0300, 1'b0};
        vecs[7] = '{1'b1, 8'h99, 16'h0099, 1'b0};
        vecs[8] = '{1'b0, 8'h01, 16'h0100, 1'b0};
        vecs[9] = '{1'b0, 8'h98, 16'h0198, 1'b0};

        rst = 1'b1; run = 1'b0; clear = 1'b0;
        bus.add_valid = 1'b0; bus.add_value = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset score", 32'(score_bcd), 32'h0);
        check("reset high", 32'(high_bcd), 32'h0);
        check("reset sat", 32'(sat), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        check("reset new_high", 32'(new_high), 32'h0);
        check("reset add_done", 32'(bus.add_done), 32'h0);
        check("reset add_ready", 32'(bus.add_ready), 32'h0);
        rst = 1'b0;

        // Tick rate: 40 edges give 10 ticks, score 0x10 lands on edge 41.
        run = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("tick rate edge %0d", k), 32'(tick), 32'((k % 4) == 0));
        end
        run = 1'b0;
        @(negedge clk);
        check("tick rate score", 32'(score_bcd), 32'h0010);
        check("tick rate high lag", 32'(high_bcd), 32'h0009);
        @(negedge clk);
        check("tick rate high", 32'(high_bcd), 32'h0010);
        check("tick rate new_high", 32'(new_high), 32'h1);
        @(negedge clk);
        check("new_high one cycle", 32'(new_high), 32'h0);

        // Run gating: count to 2, hold 10 cycles, then tick 2 edges after resume.
        do_clear();
        run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("gate pre tick", 32'(tick), 32'h0);
        end
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("gate held tick", 32'(tick), 32'h0);
        end
        run = 1'b1;
        @(negedge clk);
        check("gate resume 1", 32'(tick), 32'h0);
        @(negedge clk);
        check("gate resume 2", 32'(tick), 32'h1);
        run = 1'b0;
        @(negedge clk);
        check("gate score", 32'(score_bcd), 32'h0001);

        prior = '0;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].clr) begin
                do_clear();
                prior = '0;
            end
            bonus_add(vecs[i].value, prior, vecs[i].exp_score, vecs[i].exp_sat,
                      $sformatf("vec %0d", i));
            prior = vecs[i].exp_score;
        end

        // Tick collision: tick lands during ADD of 0x25 from 0x10.
        do_clear();
        bonus_add(8'h10, 16'h0000, 16'h0010, 1'b0, "collide setup");
        run = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_value = 8'h25;
        @(negedge clk);
        bus.add_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("collide ready %0d", k), 32'(bus.add_ready), 32'h0);
            if (k == 3) check("collide tick", 32'(tick), 32'h1);
            if (k < 5) begin
                check($sformatf("collide done %0d", k), 32'(bus.add_done), 32'h0);
                check($sformatf("collide hold %0d", k), 32'(score_bcd), 32'h0010);
            end
        end
        check("collide commit done", 32'(bus.add_done), 32'h1);
        check("collide commit score", 32'(score_bcd), 32'h0035);
        @(negedge clk);
        run = 1'b0;
        check("collide tick score", 32'(score_bcd), 32'h0036);
        check("collide ready after", 32'(bus.add_ready), 32'h1);

        // Saturation: climb to 9995, add 07, then a tick must hold 9999.
        do_clear();
        for (int i = 0; i < 100; i++)
            bonus_add(8'h99, to_bcd(99 * i), to_bcd(99 * (i + 1)), 1'b0, "sat climb");
        bonus_add(8'h95, 16'h9900, 16'h9995, 1'b0, "sat 9995");
        bonus_add(8'h07, 16'h9995, 16'h9999, 1'b1, "sat overflow");
        @(negedge clk);
        check("sat high", 32'(high_bcd), 32'h9999);
        run = 1'b1;
        ticks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        run = 1'b0;
        check("sat tick seen", 32'(ticks), 32'd1);
        check("sat tick hold", 32'(score_bcd), 32'h9999);
        check("sat tick sticky", 32'(sat), 32'h1);
        do_clear();
        check("sat clear score", 32'(score_bcd), 32'h0);
        check("sat clear sat", 32'(sat), 32'h0);
        check("sat clear high", 32'(high_bcd), 32'h9999);

        // Clear during ADD aborts without add_done.
        bonus_add(8'h20, 16'h0000, 16'h0020, 1'b0, "abort setup");
        bus.add_valid = 1'b1;
        bus.add_value = 8'h12;
        @(negedge clk);
        bus.add_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("abort no done", 32'(bus.add_done), 32'h0);
            check("abort score", 32'(score_bcd), 32'h0);
            @(negedge clk);
        end
        check("abort idle ready", 32'(bus.add_ready), 32'h1);

        // Asynchronous reset mid-ADD.
        bonus_add(8'h42, 16'h0000, 16'h0042, 1'b0, "rst setup");
        bus.add_valid = 1'b1;
        bus.add_value = 8'h11;
        @(negedge clk);
        bus.add_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst score", 32'(score_bcd), 32'h0);
        check("rst high", 32'(high_bcd), 32'h0);
        check("rst sat", 32'(sat), 32'h0);
        check("rst tick", 32'(tick), 32'h0);
        check("rst new_high", 32'(new_high), 32'h0);
        check("rst add_done", 32'(bus.add_done), 32'h0);
        check("rst add_ready", 32'(bus.add_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst no done", 32'(bus.add_done), 32'h0);
        end
        check("rst after ready", 32'(bus.add_ready), 32'h1);
        check("rst after score", 32'(score_bcd), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
